// File: rtl/aes_key_expander.sv
// AES-128 key schedule: captures a cipher key on a rising load_key, derives
// the ten following round keys at one per cycle into a register file, and
// serves any stored key combinationally by round index.
module aes_key_expander #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load_key,
  input  logic [127:0] key_in,
  input  logic [3:0]   round_sel,
  output logic [127:0] round_key,
  output logic         chg_key_done,
  output logic         keys_valid,
  output logic         busy
);

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box, row 0 (inputs 00..0f) in the most significant bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2,
    READY  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           load_q;
  logic [3:0]     ctr;
  logic [7:0]     rcon;
  logic [127:0]   rk [0:NR];

  logic           start;
  logic [3:0]     prev_idx;
  logic [127:0]   rk_prev;
  logic [31:0]    w0;
  logic [31:0]    w1;
  logic [31:0]    w2;
  logic [31:0]    w3;
  logic [31:0]    rot_w;
  logic [31:0]    sub_w;
  logic [31:0]    t_w;
  logic [31:0]    w0_n;
  logic [31:0]    w1_n;
  logic [31:0]    w2_n;
  logic [31:0]    w3_n;

  // Byte substitution; byte b sits (255-b) bytes above bit 0 of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos = {~b, 3'b000};
    return SBOX_TBL[pos +: 8];
  endfunction

  // GF(2^8) multiply by x, reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign start = load_key & ~load_q;

  // Previous round key feeding the current expansion step.
  always_comb begin
    prev_idx = ctr - 4'd1;
    rk_prev  = '0;
    if (prev_idx <= LAST) rk_prev = rk[prev_idx];
  end

  // One round of the key schedule: four S-box lookups plus the XOR chain.
  always_comb begin
    w0    = rk_prev[127:96];
    w1    = rk_prev[95:64];
    w2    = rk_prev[63:32];
    w3    = rk_prev[31:0];
    rot_w = {w3[23:0], w3[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
             sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
    t_w   = sub_w ^ {rcon, 24'h000000};
    w0_n  = w0 ^ t_w;
    w1_n  = w1 ^ w0_n;
    w2_n  = w2 ^ w1_n;
    w3_n  = w3 ^ w2_n;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a fresh load edge always (re)starts, even mid-expansion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (start) state_nxt = EXPAND;
               else if (ctr == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? EXPAND : READY;
      READY:   if (start) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  // Load edge detector, round counter and round constant.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      load_q <= 1'b0;
      ctr    <= '0;
      rcon   <= '0;
    end else begin
      load_q <= load_key;
      if (start) begin
        ctr  <= 4'd1;
        rcon <= 8'h01;
      end else if (state == EXPAND) begin
        ctr  <= ctr + 4'd1;
        rcon <= xtime(rcon);
      end
    end
  end

  // Round key file: slot 0 takes the cipher key, later slots the schedule.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (start) begin
      rk[0] <= key_in;
    end else if (state == EXPAND) begin
      rk[ctr] <= {w0_n, w1_n, w2_n, w3_n};
    end
  end

  // Status outputs decoded from state; key read-out is a plain mux.
  always_comb begin
    busy         = (state == EXPAND);
    chg_key_done = (state == DONE);
    keys_valid   = (state == DONE) || (state == READY);
    round_key    = '0;
    if (round_sel <= LAST) round_key = rk[round_sel];
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: scoreboard of expected completion cycles and
// final round keys, checked whenever the DUT pulses chg_key_done.
module tb_aes_key_expander;

  logic         clk;
  logic         n_rst;
  logic         load_key;
  logic [127:0] key_in;
  logic [3:0]   round_sel;
  logic [127:0] round_key;
  logic         chg_key_done;
  logic         keys_valid;
  logic         busy;

  aes_key_expander #(.NR(10)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_key     (load_key),
    .key_in       (key_in),
    .round_sel    (round_sel),
    .round_key    (round_key),
    .chg_key_done (chg_key_done),
    .keys_valid   (keys_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [127:0] rk10;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  int busy_cnt = 0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [0:10];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completion pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (chg_key_done) begin
      pulses <= pulses + 1;
      if (sb.size() == 0) begin
        check_val("unexpected_pulse", 128'(chg_key_done), 128'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("done_latency", 128'(cyc), 128'(e.due));
        check_val("rk10_at_done", round_key, e.rk10);
        check_val("valid_at_done", 128'(keys_valid), 128'd1);
      end
    end
  end

  // Raise load_key with a new key and record what completion should look like.
  task automatic start_key(input logic [127:0] k, input logic [127:0] rk10);
    exp_t e;
    key_in   = k;
    load_key = 1'b1;
    e.due    = cyc + 11;
    e.rk10   = rk10;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int p0;
    bit seen;
    p0   = pulses;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (pulses != p0) seen = 1'b1;
    end
    if (!seen) check_val(tag, 128'(pulses), 128'(p0 + 1));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int p0;
    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    n_rst     = 1'b0;
    load_key  = 1'b0;
    key_in    = '0;
    round_sel = 4'd0;
    #3;
    check_val("rst_done",  128'(chg_key_done), 128'd0);
    check_val("rst_valid", 128'(keys_valid),   128'd0);
    check_val("rst_busy",  128'(busy),         128'd0);
    check_val("rst_key",   round_key,          128'd0);
    #10 n_rst = 1'b1;
    step(2);

    // FIPS-197 vector; key_in changes after capture must be ignored.
    round_sel = 4'd10;
    busy_cnt  = 0;
    start_key(FIPS_KEY, fips_rk[10]);
    step(1);
    key_in = 128'(32'($urandom)) << 17;
    wait_done("fips_timeout");
    load_key = 1'b0;
    check_val("fips_busy_cycles", 128'(busy_cnt), 128'd10);
    step(1);
    for (int r = 0; r <= 10; r++) begin
      round_sel = 4'(r);
      #1;
      check_val($sformatf("fips_rk%0d", r), round_key, fips_rk[r]);
    end
    for (int r = 11; r <= 15; r++) begin
      round_sel = 4'(r);
      #1;
      check_val($sformatf("oor_rk%0d", r), round_key, 128'd0);
      check_val($sformatf("oor_valid%0d", r), 128'(keys_valid), 128'd1);
    end

    // Zero key with load_key held high for 20 cycles: a single expansion.
    round_sel = 4'd10;
    busy_cnt  = 0;
    p0        = pulses;
    start_key(128'd0, ZERO_RK10);
    step(20);
    load_key = 1'b0;
    step(2);
    check_val("hold_pulses", 128'(pulses - p0), 128'd1);
    check_val("hold_busy_cycles", 128'(busy_cnt), 128'd10);
    round_sel = 4'd1;
    #1;
    check_val("zero_rk1", round_key, ZERO_RK1);
    round_sel = 4'd10;
    #1;
    check_val("zero_rk10", round_key, ZERO_RK10);
    check_val("zero_valid", 128'(keys_valid), 128'd1);

    // Restart during expansion: only the second key completes.
    p0 = pulses;
    start_key(128'd0, ZERO_RK10);
    step(4);
    load_key = 1'b0;
    step(1);
    void'(sb.pop_back());
    start_key(FIPS_KEY, fips_rk[10]);
    wait_done("restart_timeout");
    load_key = 1'b0;
    step(3);
    check_val("restart_pulses", 128'(pulses - p0), 128'd1);
    round_sel = 4'd1;
    #1;
    check_val("restart_rk1", round_key, fips_rk[1]);

    // Reset in the middle of an expansion.
    round_sel = 4'd0;
    p0 = pulses;
    start_key(FIPS_KEY, fips_rk[10]);
    step(5);
    #2;
    n_rst = 1'b0;
    sb.delete();
    #1;
    check_val("midrst_done",  128'(chg_key_done), 128'd0);
    check_val("midrst_valid", 128'(keys_valid),   128'd0);
    check_val("midrst_busy",  128'(busy),         128'd0);
    check_val("midrst_key",   round_key,          128'd0);
    load_key = 1'b0;
    step(1);
    n_rst = 1'b1;
    step(20);
    check_val("midrst_no_pulse", 128'(pulses - p0), 128'd0);
    check_val("midrst_valid_after", 128'(keys_valid), 128'd0);
    round_sel = 4'd10;
    #1;
    check_val("midrst_rk10", round_key, 128'd0);

    check_val("sb_drained", 128'(sb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
